// File: rtl/io_pkg.sv
// Shared types and constants for the chip-side end of the I/O feeder protocol.
package io_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    // Header beat layout: N in [9:4], T in [3:0], upper bits zero.
    localparam int HDR_W     = 10;
    localparam int HDR_N_LSB = 4;
    localparam int HDR_T_LSB = 0;

    localparam logic CMD_LOAD = 1'b1;
    localparam logic CMD_PROC = 1'b0;

    typedef enum logic [2:0] {
        ST_RX,
        ST_ACK,
        ST_START,
        ST_WAIT_CORE,
        ST_TX,
        ST_HALT
    } io_state_e;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_ELEM,
        PH_FILL
    } tx_phase_e;

    function automatic logic [HDR_W-1:0] make_header(input logic [5:0] n, input logic [3:0] t);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_N_LSB +: 6] = n;
        h[HDR_T_LSB +: 4] = t;
        return h;
    endfunction

endpackage

// File: rtl/io_tx_sequencer.sv
// Result-stream beat generator: header, T vectors of N elements, one filler beat
// after each vector, with result-memory reads issued one cycle ahead of their beat.
module io_tx_sequencer
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [5:0]        n_len,
    input  logic [3:0]        t_steps,
    input  logic [DATA_W-1:0] res_rdata,
    output logic [ADDR_W-1:0] res_raddr,
    output logic              beat_valid,
    output logic [DATA_W-1:0] beat_data,
    output logic              beat_last
);

    logic              active_q, active_d;
    tx_phase_e         phase_q, phase_d;
    logic [5:0]        n_q, n_d, elem_q, elem_d;
    logic [3:0]        t_q, t_d, vec_q, vec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              empty;

    assign empty     = (n_q == 6'd0) || (t_q == 4'd0);
    assign res_raddr = addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            phase_q  <= PH_HDR;
            n_q      <= '0;
            t_q      <= '0;
            elem_q   <= '0;
            vec_q    <= '0;
            addr_q   <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            n_q      <= n_d;
            t_q      <= t_d;
            elem_q   <= elem_d;
            vec_q    <= vec_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        active_d   = active_q;
        phase_d    = phase_q;
        n_d        = n_q;
        t_d        = t_q;
        elem_d     = elem_q;
        vec_d      = vec_q;
        addr_d     = addr_q;
        beat_valid = active_q;
        beat_data  = '0;
        beat_last  = 1'b0;
        if (go) begin
            active_d = 1'b1;
            phase_d  = PH_HDR;
            n_d      = n_len;
            t_d      = t_steps;
            elem_d   = '0;
            vec_d    = '0;
            addr_d   = '0;
        end else if (active_q) begin
            case (phase_q)
                PH_HDR: begin
                    beat_data = DATA_W'(make_header(n_q, t_q));
                    phase_d   = empty ? PH_FILL : PH_ELEM;
                end
                PH_ELEM: begin
                    beat_data = res_rdata;
                    if (elem_q == n_q - 6'd1) begin
                        phase_d = PH_FILL;
                    end else begin
                        elem_d = elem_q + 6'd1;
                    end
                end
                default: begin
                    if (empty || (vec_q == t_q - 4'd1)) begin
                        active_d  = 1'b0;
                        beat_last = 1'b1;
                    end else begin
                        phase_d = PH_ELEM;
                        elem_d  = '0;
                        vec_d   = vec_q + 4'd1;
                    end
                end
            endcase
            // The address on the port now feeds the next beat, so advance only when that beat is an element.
            if (active_d && (phase_d == PH_ELEM)) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_chip_responder.sv
// Chip-side I/O feeder responder: loads packets into the input buffer, starts the
// core, then streams the result vectors back over the shared bus.
module io_chip_responder
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intrpt,
    input  logic              cmd,
    output logic              done,
    inout  wire  [DATA_W-1:0] data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              load_ovf,
    output logic              start,
    input  logic              core_done,
    input  logic [5:0]        n_len,
    input  logic [3:0]        t_steps,
    output logic [ADDR_W-1:0] res_raddr,
    input  logic [DATA_W-1:0] res_rdata
);

    io_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              tx_go, beat_valid, beat_last;
    logic [DATA_W-1:0] beat_data;

    assign tx_go = (state_q == ST_WAIT_CORE) && core_done;

    io_tx_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .go         (tx_go),
        .n_len      (n_len),
        .t_steps    (t_steps),
        .res_rdata  (res_rdata),
        .res_raddr  (res_raddr),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_last  (beat_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RX;
            armed_q <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    // A load is taken only once intrpt has been seen low, so the feeder's stale strobe is not captured twice.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RX: begin
                if (intrpt && (cmd == CMD_LOAD) && armed_q) begin
                    wdata_d = data;
                    armed_d = 1'b0;
                    state_d = ST_ACK;
                end else if (intrpt && (cmd == CMD_PROC)) begin
                    state_d = ST_START;
                end else if (!intrpt) begin
                    armed_d = 1'b1;
                end
            end
            ST_ACK: begin
                waddr_d = waddr_q + ADDR_W'(1);
                if (&waddr_q) begin
                    ovf_d = 1'b1;
                end
                state_d = ST_RX;
            end
            ST_START:     state_d = ST_WAIT_CORE;
            ST_WAIT_CORE: if (core_done) state_d = ST_TX;
            ST_TX:        if (beat_last) state_d = ST_HALT;
            default:      state_d = state_q;
        endcase
    end

    assign buf_we    = (state_q == ST_ACK);
    assign buf_waddr = waddr_q;
    assign buf_wdata = wdata_q;
    assign load_ovf  = ovf_q;
    assign start     = (state_q == ST_START);
    assign done      = (state_q == ST_ACK) || ((state_q == ST_TX) && beat_valid);
    assign data      = (state_q == ST_TX) ? beat_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_io_chip_responder.sv
// Directed self-checking bench for io_chip_responder: load handshake, process
// start, result streaming, empty result, mid-stream reset and address wrap.
module tb_io_chip_responder;

    localparam logic [31:0] PAT = 32'hC3A5_5A3C;

    logic        clk = 1'b0;
    logic        reset;
    logic        intrpt;
    logic        cmd;
    logic        done;
    wire  [31:0] data;
    logic        buf_we;
    logic [9:0]  buf_waddr;
    logic [31:0] buf_wdata;
    logic        load_ovf;
    logic        start;
    logic        core_done;
    logic [5:0]  n_len;
    logic [3:0]  t_steps;
    logic [9:0]  res_raddr;
    logic [31:0] res_rdata;

    logic [31:0] tb_data;
    logic        tb_drive;
    logic [31:0] mem [0:1023];
    logic [9:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign data = tb_drive ? tb_data : 32'bz;

    io_chip_responder dut (
        .clk       (clk),
        .reset     (reset),
        .intrpt    (intrpt),
        .cmd       (cmd),
        .done      (done),
        .data      (data),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .load_ovf  (load_ovf),
        .start     (start),
        .core_done (core_done),
        .n_len     (n_len),
        .t_steps   (t_steps),
        .res_raddr (res_raddr),
        .res_rdata (res_rdata)
    );

    // Result memory with one-cycle read latency.
    always @(posedge clk) res_rdata <= mem[res_raddr];

    always @(negedge clk) begin
        if (reset && buf_we) begin
            wr_addr_log.push_back(buf_waddr);
            wr_data_log.push_back(buf_wdata);
        end
    end

    task automatic do_reset;
        reset = 1'b0; intrpt = 1'b0; cmd = 1'b1; core_done = 1'b0;
        n_len = '0; t_steps = '0; tb_drive = 1'b1; tb_data = PAT;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    // Feeder load handshake; keeps intrpt high for one re-prepare cycle after done.
    task automatic send_word(input logic [31:0] w, output bit acked, output bit stale_done);
        @(negedge clk);
        tb_drive = 1'b1; tb_data = w; cmd = 1'b1; intrpt = 1'b1;
        acked = 1'b0;
        for (int c = 0; c < 8 && !acked; c++) begin
            @(negedge clk);
            if (done) acked = 1'b1;
        end
        @(negedge clk);
        stale_done = done;
        intrpt = 1'b0; tb_data = PAT;
    endtask

    task automatic start_process;
        @(negedge clk); intrpt = 1'b1; cmd = 1'b0;
        @(negedge clk); intrpt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; intrpt = 1'b0; cmd = 1'b1; core_done = 1'b0;
        n_len = '0; t_steps = '0; tb_drive = 1'b1; tb_data = PAT;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got=%b expected=0", done); end
        checks++; if (buf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_buf_we: got=%b expected=0", buf_we); end
        checks++; if (buf_waddr !== 10'd0) begin errors++; $display("[TB] FAIL rst_waddr: got=%0d expected=0", buf_waddr); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL rst_start: got=%b expected=0", start); end
        checks++; if (load_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf: got=%b expected=0", load_ovf); end
        checks++; if (res_raddr !== 10'd0) begin errors++; $display("[TB] FAIL rst_raddr: got=%0d expected=0", res_raddr); end
        checks++; if (data !== PAT) begin errors++; $display("[TB] FAIL rst_bus_released: got=%h expected=%h", data, PAT); end
        reset = 1'b1;
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic test_load;
        logic [31:0] words [3];
        bit acked, stale;
        words = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], acked, stale);
            checks++; if (acked !== 1'b1) begin errors++; $display("[TB] FAIL load_ack%0d: got=%b expected=1", i, acked); end
            checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL load_done_width%0d: got=%b expected=0", i, stale); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_log.size() != 3) begin
            errors++; $display("[TB] FAIL load_write_count: got=%0d expected=3", wr_addr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (wr_addr_log[i] !== 10'(i)) begin errors++; $display("[TB] FAIL load_addr%0d: got=%0d expected=%0d", i, wr_addr_log[i], i); end
                checks++; if (wr_data_log[i] !== words[i]) begin errors++; $display("[TB] FAIL load_data%0d: got=%h expected=%h", i, wr_data_log[i], words[i]); end
            end
        end
    endtask

    task automatic test_process;
        int starts, dones, writes_before;
        @(negedge clk); intrpt = 1'b1; cmd = 1'b0;
        @(negedge clk);
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse: got=%b expected=1", start); end
        intrpt = 1'b0;
        starts = 0;
        repeat (4) begin @(negedge clk); if (start) starts++; end
        checks++; if (starts != 0) begin errors++; $display("[TB] FAIL start_once: got=%0d extra expected=0", starts); end
        checks++; if (data !== PAT) begin errors++; $display("[TB] FAIL wait_bus_released: got=%h expected=%h", data, PAT); end
        writes_before = wr_addr_log.size();
        intrpt = 1'b1; cmd = 1'b1; tb_data = 32'hDEAD_BEEF;
        dones = 0;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        intrpt = 1'b0; tb_data = PAT;
        @(negedge clk);
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL wait_ignores_load_done: got=%0d expected=0", dones); end
        checks++; if (wr_addr_log.size() != writes_before) begin errors++; $display("[TB] FAIL wait_ignores_load_we: got=%0d expected=%0d", wr_addr_log.size(), writes_before); end
    endtask

    task automatic test_tx_stream;
        logic [31:0] exp_beats [10];
        int dones, starts, writes_before;
        exp_beats = '{32'h23, 32'd1, 32'd2, 32'd0, 32'd3, 32'd4, 32'd0, 32'd5, 32'd6, 32'd0};
        @(negedge clk);
        tb_drive = 1'b0; n_len = 6'd2; t_steps = 4'd3; core_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin core_done = 1'b0; n_len = 6'd7; t_steps = 4'd7; end
            checks++;
            if ({done, data} !== {1'b1, exp_beats[i]}) begin
                errors++; $display("[TB] FAIL tx_beat%0d: got done=%b data=%h expected done=1 data=%h", i, done, data, exp_beats[i]);
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL tx_end_done: got=%b expected=0", done); end
        tb_drive = 1'b1; tb_data = PAT;
        #1;
        checks++; if (data !== PAT) begin errors++; $display("[TB] FAIL tx_end_bus_released: got=%h expected=%h", data, PAT); end
        writes_before = wr_addr_log.size();
        intrpt = 1'b1; cmd = 1'b1; core_done = 1'b1;
        dones = 0; starts = 0;
        repeat (4) begin @(negedge clk); if (done) dones++; if (start) starts++; end
        intrpt = 1'b0; core_done = 1'b0;
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL halt_done: got=%0d expected=0", dones); end
        checks++; if (starts != 0) begin errors++; $display("[TB] FAIL halt_start: got=%0d expected=0", starts); end
        checks++; if (wr_addr_log.size() != writes_before) begin errors++; $display("[TB] FAIL halt_writes: got=%0d expected=%0d", wr_addr_log.size(), writes_before); end
    endtask

    task automatic test_empty_result;
        logic [31:0] exp_beats [2];
        exp_beats = '{32'h05, 32'h0};
        do_reset();
        start_process();
        tb_drive = 1'b0; n_len = 6'd0; t_steps = 4'd5; core_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            core_done = 1'b0;
            checks++;
            if ({done, data} !== {1'b1, exp_beats[i]}) begin
                errors++; $display("[TB] FAIL empty_beat%0d: got done=%b data=%h expected done=1 data=%h", i, done, data, exp_beats[i]);
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL empty_end_done: got=%b expected=0", done); end
        tb_drive = 1'b1; tb_data = PAT;
        #1;
        checks++; if (data !== PAT) begin errors++; $display("[TB] FAIL empty_bus_released: got=%h expected=%h", data, PAT); end
    endtask

    task automatic test_reset_mid_tx;
        bit acked, stale;
        do_reset();
        start_process();
        tb_drive = 1'b0; n_len = 6'd2; t_steps = 4'd3; core_done = 1'b1;
        repeat (3) begin @(negedge clk); core_done = 1'b0; end
        checks++; if ({done, data} !== {1'b1, 32'd2}) begin errors++; $display("[TB] FAIL midrst_beat2: got done=%b data=%h expected done=1 data=2", done, data); end
        reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got=%b expected=0", done); end
        tb_drive = 1'b1; tb_data = PAT;
        #1;
        checks++; if (data !== PAT) begin errors++; $display("[TB] FAIL midrst_bus_released: got=%h expected=%h", data, PAT); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr_addr_log.delete();
        wr_data_log.delete();
        send_word(32'h77, acked, stale);
        repeat (2) @(negedge clk);
        checks++; if (acked !== 1'b1) begin errors++; $display("[TB] FAIL midrst_reload_ack: got=%b expected=1", acked); end
        checks++;
        if (wr_addr_log.size() != 1) begin
            errors++; $display("[TB] FAIL midrst_reload_count: got=%0d expected=1", wr_addr_log.size());
        end else if ({wr_addr_log[0], wr_data_log[0]} !== {10'd0, 32'h77}) begin
            errors++; $display("[TB] FAIL midrst_reload_write: got addr=%0d data=%h expected addr=0 data=77", wr_addr_log[0], wr_data_log[0]);
        end
    endtask

    task automatic test_overflow;
        bit acked, stale;
        int nacks, stales;
        logic ovf_before;
        do_reset();
        nacks = 0; stales = 0; ovf_before = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            send_word(32'(i), acked, stale);
            if (!acked) nacks++;
            if (stale) stales++;
            if (i == 1022) ovf_before = load_ovf;
        end
        repeat (2) @(negedge clk);
        checks++; if (nacks != 0) begin errors++; $display("[TB] FAIL ovf_acks: got=%0d missing expected=0", nacks); end
        checks++; if (stales != 0) begin errors++; $display("[TB] FAIL ovf_done_width: got=%0d long expected=0", stales); end
        checks++; if (ovf_before !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got=%b expected=0", ovf_before); end
        checks++; if (load_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got=%b expected=1", load_ovf); end
        checks++;
        if (wr_addr_log.size() != 1025) begin
            errors++; $display("[TB] FAIL ovf_write_count: got=%0d expected=1025", wr_addr_log.size());
        end else begin
            checks++; if (wr_addr_log[1023] !== 10'd1023) begin errors++; $display("[TB] FAIL ovf_last_addr: got=%0d expected=1023", wr_addr_log[1023]); end
            checks++;
            if ({wr_addr_log[1024], wr_data_log[1024]} !== {10'd0, 32'd1024}) begin
                errors++; $display("[TB] FAIL ovf_wrap_write: got addr=%0d data=%0d expected addr=0 data=1024", wr_addr_log[1024], wr_data_log[1024]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);
        test_reset();
        test_load();
        test_process();
        test_tx_stream();
        test_empty_result();
        test_reset_mid_tx();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout expected=completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/io_chip_responder.md
Name: io_chip_responder

Overview:
- Chip-side end of the I/O feeder protocol.
- Load phase: accepts 32-bit packets on the shared `data` bus, one per `intrpt`/`done` handshake, and writes them sequentially into the input buffer.
- Process phase: on the process command, starts the solver core and waits for `core_done`.
- Result phase: drives the result stream back on the same bus: header, then X vectors, with separator/close beats.

Parameters:
- DATA_W, 32, bus and word width.
- ADDR_W, 10, input-buffer and result-memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- intrpt  in  1  feeder command strobe.
- cmd  in  1  1 = load packet, 0 = process.
- done  out  1  packet acknowledge (load phase) / result beat valid (result phase).
- data  inout  DATA_W  shared bus; driven by this block only in result-phase states, else high-Z.
- buf_we  out  1  input-buffer write enable.
- buf_waddr  out  ADDR_W  input-buffer write address.
- buf_wdata  out  DATA_W  input-buffer write data.
- load_ovf  out  1  sticky: write address wrapped past 2^ADDR_W-1.
- start  out  1  one-cycle core start pulse.
- core_done  in  1  core finished, level or pulse.
- n_len  in  6  vector length N, valid when core_done is high.
- t_steps  in  4  number of output time steps T, valid when core_done is high.
- res_raddr  out  ADDR_W  result-memory read address.
- res_rdata  in  DATA_W  result word, one-cycle read latency.

Behaviour:
- Reset (reset=0, async) forces:
  - done=0, buf_we=0, buf_waddr=0, start=0, load_ovf=0, res_raddr=0.
  - Bus released; state RX; armed=1.
  - Reset mid-transfer releases the bus in the same cycle.
- States: RX, ACK, START, WAIT_CORE, TX, HALT.
- RX:
  - intrpt=1 and cmd=1 and armed=1: register data into buf_wdata, pulse buf_we next cycle at current buf_waddr, clear armed, go ACK.
  - intrpt=1 and cmd=0: go START. No arming required; the feeder raises intrpt directly with cmd=0.
  - intrpt=0: set armed.
- ACK:
  - done=1 for exactly one cycle, then RX.
  - buf_waddr increments by 1 after each write, wrapping modulo 2^ADDR_W; wrap sets load_ovf.
  - Guarantees the stale intrpt=1 during the feeder's re-prepare cycle is never captured twice.
- START: start=1 for one cycle, then WAIT_CORE.
- WAIT_CORE: bus high-Z. On core_done=1, latch N=n_len and T=t_steps, go TX.
- TX beats: one per clock, contiguous, done=1 and data valid on every beat.
  - Beat 0 (header): data = {22'b0, N[5:0], T[3:0]}.
  - Then for v=0..T-1: N element beats with data = result word v*N+e, e=0..N-1.
  - Each vector is followed by one filler beat with data=0.
  - Filler after vectors 0..T-2 = separator (feeder writes newline); filler after vector T-1 = close beat (feeder closes file).
  - Total beats = 1 + T*(N+1).
- Result-memory reads:
  - res_raddr issued one cycle ahead of its beat, so element beats are back-to-back with no bubbles.
  - Address runs linearly 0..N*T-1; counters sized 10 bits, max 63*15=945.
- After the last beat: done=0, bus high-Z, go HALT. HALT ignores intrpt and core_done until reset.
- N=0 or T=0: header beat, then one close beat (total 2 beats), then HALT.
- Bus contention rule: the block drives data only during the TX state.
- intrpt with cmd=1 arriving in START/WAIT_CORE/TX is ignored.

Decomposition:
- Shared package `io_pkg`: state enum, DATA_W/ADDR_W defaults, header field positions (N at [9:4], T at [3:0]), cmd encodings LOAD=1/PROC=0.
- One sub-module `io_tx_sequencer`: vector/element counters, prefetch address and beat generation, started by WAIT_CORE→TX.
- Load FSM stays in the top level.

Test Plan:
- Reset, then feeder sends 3 words 0xA, 0xB, 0xC with intrpt/done protocol -> buf_we exactly 3 pulses at addresses 0,1,2 with matching data; done 1 cycle per word; no duplicate writes.
- After load, intrpt=1 cmd=0 -> start pulses once 1 cycle after RX sees it; bus stays high-Z.
- core_done with N=2, T=3, memory = 1..6 -> 10 contiguous done beats: 0x23, 1, 2, 0, 3, 4, 0, 5, 6, 0; then done=0 and bus Z.
- core_done with N=0, T=5 -> beats 0x05, 0; HALT.
- Write 1025 words with ADDR_W=10 -> word 1024 written at address 0, load_ovf=1.
- Assert reset low during the third TX beat -> done=0 and bus Z immediately; after release, a new load at address 0 succeeds.
